xor_parity_seq: RTL and testbench
=================================

Name: xor_parity_seq

Overview:
Parametrised, multi-cycle successor to the combinational XOR/parity ALU slice.
- Latches two operands on an accepted start and computes their bitwise XOR.
- Serially counts the 1-bits of the XOR result, one bit per clock, and reports even parity and the popcount.
- Returns the result sign- or zero-extended to the ALU result width.
- Sits in the ALU beside the other op units and is selected by the shared 6-bit opcode.

Parameters:
- WIDTH, 5, operand width in bits (>= 2).
- OUT_WIDTH, 32, width of `conclusion` (>= WIDTH).
- CNT_W, 3, width of `onescount`; must satisfy 2^CNT_W > WIDTH.
- OPCODE, 6'b010000, opcode value that selects this unit.

Ports:
- clk, in, 1, clock; all state changes on the rising edge.
- reset, in, 1, asynchronous, active-high; clears all state immediately.
- start, in, 1, request to begin an operation.
- printout, in, 6, opcode; compared against OPCODE when start is sampled.
- extendmode, in, 1, 1 = sign-extend from bit WIDTH-1, 0 = zero-extend; sampled with start.
- Number1, in, WIDTH, operand A.
- Number2, in, WIDTH, operand B.
- busy, out, 1, high while in COUNT.
- done, out, 1, one-cycle pulse when results are updated.
- badop, out, 1, one-cycle pulse when start is rejected because of an opcode mismatch.
- balancebit, out, 1, 1 if the XOR result has an even number of 1s (zero counts as even).
- onescount, out, CNT_W, number of 1s in the XOR result.
- conclusion, out, OUT_WIDTH, XOR result extended per the latched extendmode.

Behaviour:
- States: IDLE, COUNT, DONE. State is 2 bits; unused encodings go to IDLE.
- Reset, asynchronous and at any time including mid-COUNT:
  - state = IDLE; busy, done and badop = 0.
  - balancebit = 1, onescount = 0, conclusion = 0.
  - Internal operand register, bit index and running count = 0.
  - Any operation in progress is discarded; no done pulse is produced for it.
- IDLE or DONE, start = 1, printout == OPCODE (accepting edge E0):
  - Latch Number1^Number2 into the internal operand register and latch extendmode.
  - Set index = 0 and running count = 0; go to COUNT.
  - Accepting in DONE gives back-to-back operation with no bubble.
- IDLE or DONE, start = 1, printout != OPCODE:
  - badop = 1 for the next cycle only.
  - No state change except DONE -> IDLE.
  - Outputs are not modified.
- IDLE or DONE, start = 0: DONE -> IDLE, IDLE stays in IDLE.
- COUNT:
  - Each edge adds operand[index] to the running count and increments index.
  - The edge that processes index = WIDTH-1 goes to DONE. On that same edge:
    - onescount = final count.
    - balancebit = ~final_count[0].
    - conclusion = the latched XOR value, upper OUT_WIDTH-WIDTH bits filled with operand[WIDTH-1] (sign mode) or 0 (zero mode).
- Latency: if start is accepted at E0, results and done=1 appear after edge E_WIDTH (WIDTH clocks later). done stays high exactly one cycle.
- busy = 1 only in COUNT. start in COUNT is ignored: no badop, operands not re-latched.
- Operand, opcode and extendmode changes after E0 do not affect the operation in flight.
- Results hold their values until the next DONE entry or reset. They are not cleared on return to IDLE.
- Width rules:
  - The running count is CNT_W bits and cannot overflow, given 2^CNT_W > WIDTH.
  - If OUT_WIDTH == WIDTH, no extension bits are added.

Test Plan:
- Reset values: assert reset asynchronously between edges -> outputs immediately show busy=0, done=0, badop=0, balancebit=1, onescount=0, conclusion=0.
- Basic sign mode (WIDTH=5): Number1=5'b10110, Number2=5'b01100, printout=6'b010000, extendmode=1, start pulse -> busy high for 5 cycles, then done pulse, conclusion=32'hFFFFFFFA, onescount=3, balancebit=0. Repeat with extendmode=0 -> conclusion=32'h0000001A.
- Equal operands: 5'b10101 ^ 5'b10101 -> conclusion=0, onescount=0, balancebit=1 after 5 cycles.
- Wrong opcode and start during COUNT:
  - start with printout=6'b010001 -> badop pulse one cycle, no busy, results unchanged.
  - start asserted again during COUNT with new operands -> ignored; the first operation's results appear on schedule.
- Back-to-back: hold start high with valid opcode. Operation 1: 5'b11111^5'b00000. Operation 2, accepted in DONE: 5'b00011^5'b00000.
  - Required: done pulses exactly 6 cycles apart.
  - After op 1: onescount=5, balancebit=0, conclusion=32'hFFFFFFFF.
  - After op 2: onescount=2, balancebit=1, conclusion=32'h00000003.
- Reset mid-operation: assert reset during the 3rd COUNT cycle -> immediate IDLE and reset values, no done pulse. A new operation after reset release completes normally in 5 cycles.

Source files
------------

// File: rtl/xor_parity_seq_if.sv
// rtl/xor_parity_seq_if.sv - operand/result bundle for the serial XOR parity unit
interface xor_parity_seq_if #(
    parameter int WIDTH     = 5,
    parameter int OUT_WIDTH = 32,
    parameter int CNT_W     = 3
);
    logic                 start;
    logic [5:0]           printout;
    logic                 extendmode;
    logic [WIDTH-1:0]     Number1;
    logic [WIDTH-1:0]     Number2;
    logic                 busy;
    logic                 done;
    logic                 badop;
    logic                 balancebit;
    logic [CNT_W-1:0]     onescount;
    logic [OUT_WIDTH-1:0] conclusion;

    modport master (
        output start, printout, extendmode, Number1, Number2,
        input  busy, done, badop, balancebit, onescount, conclusion
    );

    modport slave (
        input  start, printout, extendmode, Number1, Number2,
        output busy, done, badop, balancebit, onescount, conclusion
    );
endinterface

// File: rtl/xor_parity_seq.sv
// rtl/xor_parity_seq.sv - multi-cycle XOR unit with serial popcount and parity
module xor_parity_seq #(
    parameter int         WIDTH     = 5,
    parameter int         OUT_WIDTH = 32,
    parameter int         CNT_W     = 3,
    parameter logic [5:0] OPCODE    = 6'b010000
) (
    input  logic              clk,
    input  logic              reset,
    xor_parity_seq_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;

    logic [WIDTH-1:0]     r_operand;
    logic                 r_ext;
    logic [CNT_W-1:0]     r_idx;
    logic [CNT_W-1:0]     r_count;
    logic                 r_badop;
    logic                 r_balance;
    logic [CNT_W-1:0]     r_ones;
    logic [OUT_WIDTH-1:0] r_conclusion;

    logic                 w_ready;
    logic                 w_opmatch;
    logic                 w_accept;
    logic                 w_reject;
    logic                 w_last;
    logic                 w_bit;
    logic [CNT_W-1:0]     w_count_next;
    logic [OUT_WIDTH-1:0] w_extended;

    assign w_ready      = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_opmatch    = (bus.printout == OPCODE);
    assign w_accept     = w_ready && bus.start && w_opmatch;
    assign w_reject     = w_ready && bus.start && !w_opmatch;
    assign w_last       = (r_idx == CNT_W'(WIDTH - 1));
    assign w_bit        = |(r_operand & (WIDTH'(1) << r_idx));
    assign w_count_next = r_count + CNT_W'(w_bit);

    // Sign mode replicates the top operand bit; a full-width result needs no fill.
    generate
        if (OUT_WIDTH > WIDTH) begin : g_ext
            assign w_extended = {{(OUT_WIDTH - WIDTH){r_ext & r_operand[WIDTH-1]}}, r_operand};
        end else begin : g_noext
            assign w_extended = r_operand;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = S_IDLE;
        case (r_state)
            S_IDLE:  w_next_state = w_accept ? S_COUNT : S_IDLE;
            S_COUNT: w_next_state = w_last   ? S_DONE  : S_COUNT;
            S_DONE:  w_next_state = w_accept ? S_COUNT : S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_operand    <= '0;
            r_ext        <= 1'b0;
            r_idx        <= '0;
            r_count      <= '0;
            r_badop      <= 1'b0;
            r_balance    <= 1'b1;
            r_ones       <= '0;
            r_conclusion <= '0;
        end else begin
            r_badop <= w_reject;
            if (w_accept) begin
                r_operand <= bus.Number1 ^ bus.Number2;
                r_ext     <= bus.extendmode;
                r_idx     <= '0;
                r_count   <= '0;
            end else if (r_state == S_COUNT) begin
                r_idx   <= r_idx + CNT_W'(1);
                r_count <= w_count_next;
                if (w_last) begin
                    r_ones       <= w_count_next;
                    r_balance    <= ~w_count_next[0];
                    r_conclusion <= w_extended;
                end
            end
        end
    end

    // DONE lasts exactly one cycle, so the state itself forms the done pulse.
    assign bus.busy       = (r_state == S_COUNT);
    assign bus.done       = (r_state == S_DONE);
    assign bus.badop      = r_badop;
    assign bus.balancebit = r_balance;
    assign bus.onescount  = r_ones;
    assign bus.conclusion = r_conclusion;

endmodule

// File: tb/tb_xor_parity_seq.sv
// tb/tb_xor_parity_seq.sv - directed self-checking bench for xor_parity_seq
module tb_xor_parity_seq;

    localparam logic [5:0] OPC = 6'b010000;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    xor_parity_seq_if #(.WIDTH(5), .OUT_WIDTH(32), .CNT_W(3)) bus ();

    xor_parity_seq #(
        .WIDTH(5), .OUT_WIDTH(32), .CNT_W(3), .OPCODE(OPC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_results(input string tag, input logic [31:0] e_concl,
                                 input logic [2:0] e_ones, input logic e_bal);
        check({tag, " conclusion"}, bus.conclusion, e_concl);
        check({tag, " onescount"}, 32'(bus.onescount), 32'(e_ones));
        check({tag, " balancebit"}, 32'(bus.balancebit), 32'(e_bal));
    endtask

    // Issue one accepted operation and measure edges from acceptance to done.
    task automatic run_op(input string tag, input logic [4:0] n1, input logic [4:0] n2,
                          input logic ext, input logic [31:0] e_concl,
                          input logic [2:0] e_ones, input logic e_bal);
        int lat;
        bit got;
        @(negedge clk);
        bus.Number1 = n1; bus.Number2 = n2; bus.extendmode = ext;
        bus.printout = OPC; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        check({tag, " busy"}, 32'(bus.busy), 32'd1);
        lat = 0; got = 0;
        while (!got && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (bus.done === 1'b1) got = 1;
        end
        check({tag, " latency"}, got ? lat : 0, 32'd5);
        check_results(tag, e_concl, e_ones, e_bal);
        @(negedge clk);
        check({tag, " done one cycle"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int  k;
        int  d1;
        int  d2;
        clk = 0; reset = 0; n_pass = 0; n_total = 0;
        bus.start = 0; bus.printout = 6'd0; bus.extendmode = 0;
        bus.Number1 = '0; bus.Number2 = '0;

        // asynchronous reset before any clock edge
        #3 reset = 1;
        #1;
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst done", 32'(bus.done), 32'd0);
        check("rst badop", 32'(bus.badop), 32'd0);
        check_results("rst", 32'h0, 3'd0, 1'b1);
        @(negedge clk); @(negedge clk);
        reset = 0;

        run_op("sign", 5'b10110, 5'b01100, 1'b1, 32'hFFFFFFFA, 3'd3, 1'b0);
        run_op("zero", 5'b10110, 5'b01100, 1'b0, 32'h0000001A, 3'd3, 1'b0);

        // wrong opcode: badop pulse only, results untouched
        @(negedge clk);
        bus.printout = 6'b010001; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("badop pulse", 32'(bus.badop), 32'd1);
        check("badop busy", 32'(bus.busy), 32'd0);
        check_results("badop hold", 32'h0000001A, 3'd3, 1'b0);
        @(negedge clk);
        check("badop cleared", 32'(bus.badop), 32'd0);
        check("badop idle", 32'(bus.busy), 32'd0);

        run_op("equal", 5'b10101, 5'b10101, 1'b1, 32'h0, 3'd0, 1'b1);

        // start during COUNT with new operands is ignored
        @(negedge clk);
        bus.Number1 = 5'b01111; bus.Number2 = 5'b00000; bus.extendmode = 0;
        bus.printout = OPC; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.Number1 = 5'b11111; bus.Number2 = 5'b00001; bus.extendmode = 1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("cnt start badop", 32'(bus.badop), 32'd0);
        check("cnt start busy", 32'(bus.busy), 32'd1);
        k = 2; d1 = 0;
        while (d1 == 0 && k < 20) begin
            @(posedge clk);
            @(negedge clk);
            k++;
            if (bus.done === 1'b1) d1 = k;
        end
        check("cnt start latency", d1, 32'd5);
        check_results("cnt start", 32'h0000000F, 3'd4, 1'b1);

        // back-to-back: start held, second op accepted in DONE
        @(negedge clk); @(negedge clk);
        bus.Number1 = 5'b11111; bus.Number2 = 5'b00000; bus.extendmode = 1;
        bus.printout = OPC; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.Number1 = 5'b00011;
        d1 = 0; d2 = 0;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk); #1;
            if (e == 6) bus.start = 1'b0;
            @(negedge clk);
            if (bus.done === 1'b1) begin
                if (d1 == 0) begin
                    d1 = e;
                    check_results("b2b op1", 32'hFFFFFFFF, 3'd5, 1'b0);
                end else if (d2 == 0) begin
                    d2 = e;
                    check_results("b2b op2", 32'h00000003, 3'd2, 1'b1);
                end
            end
        end
        bus.start = 1'b0;
        check("b2b first done", d1, 32'd5);
        check("b2b spacing", (d2 != 0) ? d2 - d1 : 0, 32'd6);

        // reset during the third COUNT cycle
        @(negedge clk);
        bus.Number1 = 5'b11111; bus.Number2 = 5'b00000; bus.extendmode = 1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check("midrst busy", 32'(bus.busy), 32'd0);
        check("midrst done", 32'(bus.done), 32'd0);
        check_results("midrst", 32'h0, 3'd0, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        d1 = 0;
        for (int e = 0; e < 8; e++) begin
            @(negedge clk);
            if (bus.done !== 1'b0) d1++;
        end
        check("midrst no done", d1, 32'd0);

        run_op("after rst", 5'b00001, 5'b00000, 1'b1, 32'h00000001, 3'd1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish, %0d of %0d passed", n_pass, n_total);
        $fatal(1, "timeout");
    end

endmodule
